// File: rtl/xor_checksum_checker.sv
// Receive-side XOR-checksum frame checker: accumulates payload words, compares
// the trailing checksum word and reports ok/overlong/count over valid/ready.
module xor_checksum_checker #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_WORDS = 16,
  parameter int unsigned CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ok,
  output logic             out_overlong,
  output logic [CW-1:0]    out_count
);

  localparam logic [0:0]    ACCUM  = 1'b0;
  localparam logic [0:0]    REPORT = 1'b1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  logic [0:0]       state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             ovl, ovl_nxt;
  logic             in_ready_nxt, out_valid_nxt, out_ok_nxt, out_overlong_nxt;
  logic [CW-1:0]    out_count_nxt;

  // State and registered outputs; in_ready stays low while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ACCUM;
      acc          <= '0;
      count        <= '0;
      ovl          <= 1'b0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_ok       <= 1'b0;
      out_overlong <= 1'b0;
      out_count    <= '0;
    end else begin
      state        <= state_nxt;
      acc          <= acc_nxt;
      count        <= count_nxt;
      ovl          <= ovl_nxt;
      in_ready     <= in_ready_nxt;
      out_valid    <= out_valid_nxt;
      out_ok       <= out_ok_nxt;
      out_overlong <= out_overlong_nxt;
      out_count    <= out_count_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt        = state;
    acc_nxt          = acc;
    count_nxt        = count;
    ovl_nxt          = ovl;
    in_ready_nxt     = in_ready;
    out_valid_nxt    = out_valid;
    out_ok_nxt       = out_ok;
    out_overlong_nxt = out_overlong;
    out_count_nxt    = out_count;

    case (state)
      ACCUM: begin
        in_ready_nxt = 1'b1;
        if (in_valid && in_ready) begin
          if (in_last) begin
            out_ok_nxt       = ((acc ^ in_data) == '0) && !ovl;
            out_overlong_nxt = ovl;
            out_count_nxt    = count;
            out_valid_nxt    = 1'b1;
            in_ready_nxt     = 1'b0;
            state_nxt        = REPORT;
          end else begin
            acc_nxt = acc ^ in_data;
            // Count saturates; any word beyond the limit marks the frame overlong.
            if (count == MAX_CNT) begin
              ovl_nxt = 1'b1;
            end else begin
              count_nxt = count + CW'(1);
            end
          end
        end
      end
      REPORT: begin
        in_ready_nxt  = 1'b0;
        out_valid_nxt = 1'b1;
        if (out_ready) begin
          acc_nxt       = '0;
          count_nxt     = '0;
          ovl_nxt       = 1'b0;
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
          state_nxt     = ACCUM;
        end
      end
      default: begin
        state_nxt = ACCUM;
      end
    endcase
  end

endmodule

// File: tb/tb_xor_checksum_checker.sv
// Scoreboard bench for xor_checksum_checker: directed frames push expected
// status into a queue, an independent monitor pops on every status handshake.
module tb_xor_checksum_checker;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned MAX_WORDS = 4;
  localparam int unsigned CW        = $clog2(MAX_WORDS + 1);

  typedef struct packed {
    logic          ok;
    logic          ovl;
    logic [CW-1:0] cnt;
  } status_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_ok;
  logic             out_overlong;
  logic [CW-1:0]    out_count;

  int total = 0;
  int bad   = 0;
  status_t exp_q[$];

  xor_checksum_checker #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ok(out_ok), .out_overlong(out_overlong), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Hold a beat until the DUT takes it (bounded wait).
  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    int n;
    n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_status(input logic ok, input logic ovl, input int cnt);
    status_t s;
    s.ok  = ok;
    s.ovl = ovl;
    s.cnt = CW'(cnt);
    exp_q.push_back(s);
  endtask

  // Monitor: compare whenever a status handshake will complete at the next edge.
  always @(negedge clk) begin
    status_t e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_status", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_ok", int'(out_ok), int'(e.ok));
        check("out_overlong", int'(out_overlong), int'(e.ovl));
        check("out_count", int'(out_count), int'(e.cnt));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok_h, ovl_h;
    logic [CW-1:0] cnt_h;
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_ok", int'(out_ok), 0);
    check("rst_out_count", int'(out_count), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check("post_rst_ready_low", int'(in_ready), 0);
    @(posedge clk); #1;
    check("post_rst_ready_high", int'(in_ready), 1);

    // Good frame, with latency check.
    send(32'h0000_00FF, 1'b0);
    send(32'h0000_FF00, 1'b0);
    expect_status(1'b1, 1'b0, 2);
    send(32'h0000_FFFF, 1'b1);
    check("latency_valid", int'(out_valid), 1);
    check("latency_ready_low", int'(in_ready), 0);

    // Bad checksum, then clean frame proves the accumulator was cleared.
    send(32'h0000_00FF, 1'b0);
    send(32'h0000_FF00, 1'b0);
    expect_status(1'b0, 1'b0, 2);
    send(32'h0000_FFFE, 1'b1);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    expect_status(1'b1, 1'b0, 2);
    send(32'h0000_0000, 1'b1);

    // Single-beat frames.
    expect_status(1'b1, 1'b0, 0);
    send(32'h0000_0000, 1'b1);
    expect_status(1'b0, 1'b0, 0);
    send(32'h0000_0001, 1'b1);

    // Overlong: five payload words with MAX_WORDS=4.
    for (int i = 0; i < 5; i++) send(32'h0000_0001, 1'b0);
    expect_status(1'b0, 1'b1, 4);
    send(32'h0000_0001, 1'b1);

    // Backpressure with the next frame's first word waiting.
    send(32'h0000_0003, 1'b0);
    out_ready = 1'b0;
    expect_status(1'b1, 1'b0, 1);
    send(32'h0000_0003, 1'b1);
    in_data  = 32'h0000_0010;
    in_last  = 1'b0;
    in_valid = 1'b1;
    ok_h  = out_ok;
    ovl_h = out_overlong;
    cnt_h = out_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_ok_stable", int'(out_ok), int'(ok_h));
      check("bp_ovl_stable", int'(out_overlong), int'(ovl_h));
      check("bp_cnt_stable", int'(out_count), int'(cnt_h));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 1);
    send(32'h0000_0010, 1'b0);
    send(32'h0000_0020, 1'b0);
    expect_status(1'b1, 1'b0, 2);
    send(32'h0000_0030, 1'b1);

    // Reset mid-frame discards it without a status.
    send(32'h0000_0001, 1'b0);
    send(32'h0000_0002, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_count", int'(out_count), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    send(32'hA5A5_A5A5, 1'b0);
    expect_status(1'b1, 1'b0, 1);
    send(32'hA5A5_A5A5, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
